// File: rtl/dots_level_ctrl.sv
// dots_level_ctrl: game-flow controller for a maze game.
// It sequences IDLE -> INIT -> READY -> PLAY and then on to DEATH, CLEAR or GAMEOVER.
// It also keeps lives and level, runs frightened mode and the ghost bonus chain.
// Optional feature macro: FRIGHT_FLASH_EN. When defined, the block drives fright_flash
// during the last 120 frightened frames. When undefined, fright_flash is tied to 0.
//
// Input handshake: every input is sampled on the rising clk edge. The pulse inputs
// (frame_tick, big_gum_eat, ghost_eaten, pacman_dead) count once per cycle they are high.
// all_dots_eat and start are treated as levels and act on every cycle they are high.
module dots_level_ctrl #(
    parameter int INIT_CYCLES   = 32,
    parameter int READY_FRAMES  = 180,
    parameter int CLEAR_FRAMES  = 120,
    parameter int FRIGHT_FRAMES = 360,
    parameter int START_LIVES   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        big_gum_eat,
    input  logic        all_dots_eat,
    input  logic        ghost_eaten,
    input  logic        pacman_dead,
    output logic        restart_dots,
    output logic        freeze,
    output logic        frightened,
    output logic        fright_flash,
    output logic        bonus_valid,
    output logic [10:0] bonus_points,
    output logic [3:0]  level,
    output logic [1:0]  lives,
    output logic        game_over,
    output logic [2:0]  phase
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_INIT     = 3'd1;
    localparam logic [2:0] S_READY    = 3'd2;
    localparam logic [2:0] S_PLAY     = 3'd3;
    localparam logic [2:0] S_DEATH    = 3'd4;
    localparam logic [2:0] S_CLEAR    = 3'd5;
    localparam logic [2:0] S_GAMEOVER = 3'd6;

    localparam logic [15:0] INIT_LAST   = 16'(INIT_CYCLES - 1);
    localparam logic [15:0] READY_LAST  = 16'(READY_FRAMES - 1);
    localparam logic [15:0] CLEAR_LAST  = 16'(CLEAR_FRAMES - 1);
    localparam logic [15:0] FRIGHT_LOAD = 16'(FRIGHT_FRAMES);
    localparam logic [1:0]  LIVES_LOAD  = 2'(START_LIVES);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [15:0] cyc_cnt;
    logic [15:0] frame_cnt;
    logic [15:0] fright_cnt;
    logic [1:0]  chain_idx;
    logic [1:0]  lives_q;
    logic [3:0]  level_q;
    logic        frame_state;
    logic        frames_done;
    logic        in_play;
    logic        leave_play;
    logic        ghost_hit;

    // Frame-counting states and the frame that ends the current pause.
    always_comb begin
        frame_state = (state == S_READY) || (state == S_DEATH) || (state == S_CLEAR);
        frames_done = 1'b0;
        if (frame_tick) begin
            if (state == S_READY) begin
                frames_done = (frame_cnt == READY_LAST);
            end else if ((state == S_DEATH) || (state == S_CLEAR)) begin
                frames_done = (frame_cnt == CLEAR_LAST);
            end
        end
    end

    // Next-state decode. all_dots_eat takes precedence over pacman_dead in PLAY.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_INIT;
            S_INIT:     if (cyc_cnt == INIT_LAST) state_nxt = S_READY;
            S_READY:    if (frames_done) state_nxt = S_PLAY;
            S_PLAY: begin
                if (all_dots_eat) begin
                    state_nxt = S_CLEAR;
                end else if (pacman_dead) begin
                    state_nxt = S_DEATH;
                end
            end
            S_DEATH:    if (frames_done) state_nxt = (lives_q == 2'd0) ? S_GAMEOVER : S_READY;
            S_CLEAR:    if (frames_done) state_nxt = S_INIT;
            S_GAMEOVER: if (start) state_nxt = S_INIT;
            default:    state_nxt = S_IDLE;
        endcase
    end

    assign in_play    = (state == S_PLAY);
    assign leave_play = in_play && (state_nxt != S_PLAY);
    // A ghost counts if fright is running, or if a big gum arrives in the same cycle.
    assign ghost_hit  = in_play && ghost_eaten && (big_gum_eat || (fright_cnt != 16'd0));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Cycle and frame counters. Both reload on every state entry, so a tick in the entry cycle counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_cnt   <= 16'd0;
            frame_cnt <= 16'd0;
        end else if (state_nxt != state) begin
            cyc_cnt   <= 16'd0;
            frame_cnt <= 16'd0;
        end else begin
            if (state == S_INIT) begin
                cyc_cnt <= cyc_cnt + 16'd1;
            end
            if (frame_tick && frame_state) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Lives and level. Both load on a new game, lives drop on death, and level rises on clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lives_q <= 2'd0;
            level_q <= 4'd1;
        end else begin
            if (((state == S_IDLE) || (state == S_GAMEOVER)) && (state_nxt == S_INIT)) begin
                lives_q <= LIVES_LOAD;
                level_q <= 4'd1;
            end
            if (in_play && (state_nxt == S_DEATH) && (lives_q != 2'd0)) begin
                lives_q <= lives_q - 2'd1;
            end
            if ((state == S_CLEAR) && (state_nxt == S_INIT) && (level_q != 4'd15)) begin
                level_q <= level_q + 4'd1;
            end
        end
    end

    // Fright counter and ghost chain. They run only in PLAY and clear on the way out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fright_cnt <= 16'd0;
            chain_idx  <= 2'd0;
        end else if (!in_play || leave_play) begin
            fright_cnt <= 16'd0;
            chain_idx  <= 2'd0;
        end else if (big_gum_eat) begin
            fright_cnt <= FRIGHT_LOAD;
            chain_idx  <= ghost_eaten ? 2'd1 : 2'd0;
        end else begin
            if (frame_tick && (fright_cnt != 16'd0)) begin
                fright_cnt <= fright_cnt - 16'd1;
            end
            if (ghost_hit && (chain_idx != 2'd3)) begin
                chain_idx <= chain_idx + 2'd1;
            end
        end
    end

    // Bonus award is registered one cycle after the ghost hit. The points hold between awards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bonus_valid  <= 1'b0;
            bonus_points <= 11'd0;
        end else begin
            bonus_valid <= ghost_hit;
            if (ghost_hit) begin
                bonus_points <= 11'd200 << (big_gum_eat ? 2'd0 : chain_idx);
            end
        end
    end

    assign restart_dots = (state == S_INIT) && (cyc_cnt == 16'd0);
    assign freeze       = (state != S_PLAY);
    assign frightened   = (fright_cnt != 16'd0);
    assign game_over    = (state == S_GAMEOVER);
    assign level        = level_q;
    assign lives        = lives_q;
    assign phase        = state;

`ifdef FRIGHT_FLASH_EN
    assign fright_flash = (fright_cnt != 16'd0) && (fright_cnt <= 16'd120) && fright_cnt[3];
`else
    assign fright_flash = 1'b0;
`endif

endmodule

// File: tb/tb_dots_level_ctrl.sv
// tb_dots_level_ctrl: randomized bench for dots_level_ctrl. The bench keeps a behavioural
// game model that counts down the time left in each phase, and checks every output
// on each falling edge. Hand-computed literal checks pin the main scenarios.
module tb_dots_level_ctrl;

  localparam int INIT_CYCLES   = 32;
  localparam int READY_FRAMES  = 180;
  localparam int CLEAR_FRAMES  = 120;
  localparam int FRIGHT_FRAMES = 360;
  localparam int START_LIVES   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        big_gum_eat = 1'b0;
  logic        all_dots_eat = 1'b0;
  logic        ghost_eaten = 1'b0;
  logic        pacman_dead = 1'b0;
  logic        restart_dots;
  logic        freeze;
  logic        frightened;
  logic        fright_flash;
  logic        bonus_valid;
  logic [10:0] bonus_points;
  logic [3:0]  level;
  logic [1:0]  lives;
  logic        game_over;
  logic [2:0]  phase;

  dots_level_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .start        (start),
    .big_gum_eat  (big_gum_eat),
    .all_dots_eat (all_dots_eat),
    .ghost_eaten  (ghost_eaten),
    .pacman_dead  (pacman_dead),
    .restart_dots (restart_dots),
    .freeze       (freeze),
    .frightened   (frightened),
    .fright_flash (fright_flash),
    .bonus_valid  (bonus_valid),
    .bonus_points (bonus_points),
    .level        (level),
    .lives        (lives),
    .game_over    (game_over),
    .phase        (phase)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int exp_b [5] = '{200, 400, 800, 1600, 1600};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_rem holds the cycles (INIT) or frames (READY/DEATH/CLEAR) still left in the phase.
  int m_phase, m_rem, m_lives, m_level, m_fright, m_idx, m_bv, m_pts, m_first;

  task automatic model_reset();
    m_phase = 0; m_rem = 0; m_lives = 0; m_level = 1;
    m_fright = 0; m_idx = 0; m_bv = 0; m_pts = 0; m_first = 0;
  endtask

  task automatic enter_init();
    m_phase = 1; m_rem = INIT_CYCLES; m_first = 1;
  endtask

  // One clock edge of game rules applied to the inputs currently driven.
  task automatic model_step();
    int ph;
    ph = m_phase;
    m_first = 0;
    m_bv = 0;
    case (ph)
      0, 6: if (start) begin
        m_lives = START_LIVES; m_level = 1; enter_init();
      end
      1: begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin m_phase = 2; m_rem = READY_FRAMES; end
      end
      2: if (frame_tick) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_phase = 3;
      end
      3: begin
        if (ghost_eaten && (big_gum_eat || m_fright > 0)) begin
          m_bv = 1;
          m_pts = 200 * (2 ** (big_gum_eat ? 0 : m_idx));
        end
        if (big_gum_eat) begin
          m_fright = FRIGHT_FRAMES;
          m_idx = ghost_eaten ? 1 : 0;
        end else begin
          if (ghost_eaten && m_fright > 0) m_idx = (m_idx < 3) ? m_idx + 1 : 3;
          if (frame_tick && m_fright > 0) m_fright = m_fright - 1;
        end
        if (all_dots_eat) begin
          m_phase = 5; m_rem = CLEAR_FRAMES; m_fright = 0; m_idx = 0;
        end else if (pacman_dead) begin
          m_phase = 4; m_rem = CLEAR_FRAMES; m_fright = 0; m_idx = 0;
          m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        end
      end
      4: if (frame_tick) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          if (m_lives == 0) m_phase = 6;
          else begin m_phase = 2; m_rem = READY_FRAMES; end
        end
      end
      5: if (frame_tick) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_level = (m_level < 15) ? m_level + 1 : 15;
          enter_init();
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  function automatic int exp_flash();
`ifdef FRIGHT_FLASH_EN
    return (m_fright > 0 && m_fright <= 120 && ((m_fright / 8) % 2) == 1) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("phase",        int'(phase),        m_phase);
      chk("restart_dots", int'(restart_dots), m_first);
      chk("freeze",       int'(freeze),       (m_phase != 3) ? 1 : 0);
      chk("frightened",   int'(frightened),   (m_fright > 0) ? 1 : 0);
      chk("fright_flash", int'(fright_flash), exp_flash());
      chk("bonus_valid",  int'(bonus_valid),  m_bv);
      chk("bonus_points", int'(bonus_points), m_pts);
      chk("level",        int'(level),        m_level);
      chk("lives",        int'(lives),        m_lives);
      chk("game_over",    int'(game_over),    (m_phase == 6) ? 1 : 0);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic bit one_in(input int n);
    return ($urandom_range(0, n - 1) == 0);
  endfunction

  // Drive one cycle of inputs, step the model at the rising edge, and return at the next falling edge.
  task automatic drive(input bit ft, input bit st, input bit gum, input bit all,
                       input bit gh, input bit dead);
    frame_tick = ft; start = st; big_gum_eat = gum;
    all_dots_eat = all; ghost_eaten = gh; pacman_dead = dead;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Random frame ticks until the phase is reached. Outside PLAY, noise is injected on
  // the inputs that must be ignored there.
  task automatic run_to(input int target, input int budget);
    int n;
    bit noisy, idle_like;
    n = 0;
    while (int'(phase) != target && n < budget) begin
      noisy = (phase != 3'd3);
      idle_like = (phase == 3'd0) || (phase == 3'd6);
      drive(bit'($urandom_range(0, 1)), noisy && !idle_like && one_in(8),
            noisy && one_in(8), noisy && one_in(8), noisy && one_in(8), noisy && one_in(8));
      n++;
    end
    chk("run_to_phase", int'(phase), target);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n_cnt, b;
    bit ft;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_phase", int'(phase), 0);
    chk("rst_lives", int'(lives), 0);
    chk("rst_level", int'(level), 1);
    chk("rst_freeze", int'(freeze), 1);
    chk("rst_restart", int'(restart_dots), 0);
    chk("rst_bonus", int'(bonus_points), 0);
    reset = 1'b0;

    // Idle without start stays idle; start enters INIT with a single reload pulse.
    drive(1, 0, 1, 0, 1, 1);
    chk("idle_hold", int'(phase), 0);
    drive(bit'($urandom_range(0, 1)), 1, 0, 0, 0, 0);
    chk("start_phase", int'(phase), 1);
    chk("start_restart", int'(restart_dots), 1);
    chk("start_lives", int'(lives), 3);
    n_cnt = 1; b = 0;
    while (phase == 3'd1 && b < 200) begin
      drive(bit'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
      if (phase == 3'd1) n_cnt++;
      b++;
    end
    chk("init_cycles", n_cnt, 32);
    chk("ready_entry", int'(phase), 2);

    // READY lasts 180 frame ticks, counted only while READY.
    n_cnt = 0; b = 0;
    while (phase == 3'd2 && b < 2000) begin
      ft = bit'($urandom_range(0, 1));
      if (ft) n_cnt++;
      drive(ft, 0, 0, 0, 0, 0);
      b++;
    end
    chk("ready_ticks", n_cnt, 180);
    chk("play_phase", int'(phase), 3);
    chk("play_freeze", int'(freeze), 0);

    // Ghost chain: 200, 400, 800, 1600, then saturate at 1600.
    drive(0, 0, 1, 0, 0, 0);
    chk("gum_fright", int'(frightened), 1);
    for (int k = 0; k < 5; k++) begin
      repeat (2) drive(bit'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
      drive(bit'($urandom_range(0, 1)), 0, 0, 0, 1, 0);
      chk("chain_valid", int'(bonus_valid), 1);
      chk("chain_points", int'(bonus_points), exp_b[k]);
    end

    // A fresh gum lasts exactly 360 frame ticks.
    drive(0, 0, 1, 0, 0, 0);
    n_cnt = 0; b = 0;
    while (frightened && b < 3000) begin
      ft = bit'($urandom_range(0, 1));
      if (ft) n_cnt++;
      drive(ft, 0, 0, 0, one_in(16), 0);
      b++;
    end
    chk("fright_ticks", n_cnt, 360);
    drive(0, 0, 0, 0, 1, 0);
    chk("ghost_ignored", int'(bonus_valid), 0);

    // Counter at 50, then gum together with ghost pays 200 and restarts the chain at 1.
    drive(0, 0, 1, 0, 0, 0);
    b = 0;
    while (m_fright != 50 && b < 3000) begin
      drive(bit'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
      b++;
    end
    chk("fright_at_50", m_fright, 50);
    drive(bit'($urandom_range(0, 1)), 0, 1, 0, 1, 0);
    chk("gum_ghost_valid", int'(bonus_valid), 1);
    chk("gum_ghost_points", int'(bonus_points), 200);
    repeat (3) drive(1, 0, 0, 0, 0, 0);
    chk("reload_fright", int'(frightened), 1);
    drive(0, 0, 0, 0, 1, 0);
    chk("next_ghost", int'(bonus_points), 400);

    // Random play with gums and ghosts.
    repeat (400) drive(bit'($urandom_range(0, 1)), 0, one_in(40), 0, one_in(6), 0);

    // All dots plus death in one cycle: the clear wins and lives are kept.
    drive(bit'($urandom_range(0, 1)), 0, 0, 1, 0, 1);
    chk("clear_phase", int'(phase), 5);
    chk("clear_lives", int'(lives), 3);
    chk("clear_fright", int'(frightened), 0);
    run_to(1, 2000);
    chk("clear_level", int'(level), 2);
    chk("clear_restart", int'(restart_dots), 1);
    run_to(3, 3000);

    // Three deaths lead to game over. Respawns do not reload the dots.
    for (int i = 0; i < 3; i++) begin
      drive(bit'($urandom_range(0, 1)), 0, 0, 0, 0, 1);
      chk("death_phase", int'(phase), 4);
      chk("death_lives", int'(lives), 2 - i);
      if (i < 2) begin
        run_to(2, 2000);
        chk("respawn_restart", int'(restart_dots), 0);
        run_to(3, 3000);
        if (i == 0) repeat (50) drive(bit'($urandom_range(0, 1)), 0, one_in(20), 0, one_in(5), 0);
      end else begin
        run_to(6, 2000);
        chk("gameover_flag", int'(game_over), 1);
      end
    end
    drive(0, 1, 0, 0, 0, 0);
    chk("restart_phase", int'(phase), 1);
    chk("restart_lives", int'(lives), 3);
    chk("restart_level", int'(level), 1);
    chk("restart_pulse", int'(restart_dots), 1);

    // Reset during CLEAR acts at once; the block then waits for a new start.
    run_to(3, 4000);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("clear2_phase", int'(phase), 5);
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_phase", int'(phase), 0);
    chk("async_restart", int'(restart_dots), 0);
    chk("async_freeze", int'(freeze), 1);
    chk("async_lives", int'(lives), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      drive(bit'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
      chk("post_reset_idle", int'(phase), 0);
    end
    drive(0, 1, 0, 0, 0, 0);
    chk("post_reset_start", int'(restart_dots), 1);
    drive(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
